// File: rtl/alu_exec_unit_pkg.sv
// Shared RISC-V execute definitions: opcodes, funct3 codes, ROB tag width and stage payload structs.
// prep_exe() does the operand select and the pc+4 / pc+imm adds that sit ahead of the ALU proper.
package alu_exec_unit_pkg;

  localparam int XLEN  = 32;
  localparam int ROB_W = 4;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            f7b;
    logic [XLEN-1:0] v1;
    logic [XLEN-1:0] v2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
  } issue_t;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            f7b;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_plus_imm;
  } exe_t;

  function automatic exe_t prep_exe(input issue_t i);
    exe_t e;
    e.opcode      = i.opcode;
    e.funct3      = i.funct3;
    e.f7b         = i.f7b;
    e.src1        = i.v1;
    e.src2        = (i.opcode == OPC_OPIMM) ? i.imm : i.v2;
    e.imm         = i.imm;
    e.pc_plus4    = i.pc + 32'd4;
    e.pc_plus_imm = i.pc + i.imm;
    return e;
  endfunction

endpackage

// File: rtl/alu_compute.sv
// Combinational ALU / branch resolver: result value, taken flag and next PC from a prepared op.
module alu_compute
  import alu_exec_unit_pkg::*;
(
  input  exe_t            exe,
  output logic [XLEN-1:0] val,
  output logic            jump,
  output logic [XLEN-1:0] target
);

  logic [4:0]      shamt;
  logic            eq;
  logic            lt_s;
  logic            lt_u;
  logic            take;
  logic [XLEN-1:0] jalr_sum;

  assign shamt    = exe.src2[4:0];
  assign eq       = (exe.src1 == exe.src2);
  assign lt_s     = ($signed(exe.src1) < $signed(exe.src2));
  assign lt_u     = (exe.src1 < exe.src2);
  assign jalr_sum = exe.src1 + exe.imm;

  always_comb begin
    take = 1'b0;
    case (exe.funct3)
      F3_BEQ:  take = eq;
      F3_BNE:  take = !eq;
      F3_BLT:  take = lt_s;
      F3_BGE:  take = !lt_s;
      F3_BLTU: take = lt_u;
      F3_BGEU: take = !lt_u;
      default: take = 1'b0;
    endcase
  end

  always_comb begin
    val    = '0;
    jump   = 1'b0;
    target = exe.pc_plus4;
    case (exe.opcode)
      OPC_LUI:   val = exe.imm;
      OPC_AUIPC: val = exe.pc_plus_imm;
      OPC_JAL: begin
        val    = exe.pc_plus4;
        jump   = 1'b1;
        target = exe.pc_plus_imm;
      end
      OPC_JALR: begin
        val    = exe.pc_plus4;
        jump   = 1'b1;
        target = {jalr_sum[XLEN-1:1], 1'b0};
      end
      OPC_BRANCH: begin
        jump = take;
        if (take) target = exe.pc_plus_imm;
      end
      OPC_OPIMM, OPC_OP: begin
        case (exe.funct3)
          // imm[10] aliases funct7[5] for OP-IMM, so only OP may subtract
          F3_ADD:  val = (exe.opcode == OPC_OP && exe.f7b) ? exe.src1 - exe.src2
                                                            : exe.src1 + exe.src2;
          F3_SLL:  val = exe.src1 << shamt;
          F3_SLT:  val = {{(XLEN-1){1'b0}}, lt_s};
          F3_SLTU: val = {{(XLEN-1){1'b0}}, lt_u};
          F3_XOR:  val = exe.src1 ^ exe.src2;
          F3_SR:   val = exe.f7b ? $unsigned($signed(exe.src1) >>> shamt) : exe.src1 >> shamt;
          F3_OR:   val = exe.src1 | exe.src2;
          F3_AND:  val = exe.src1 & exe.src2;
          default: val = '0;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Integer execute unit: issue captured at edge N, broadcast after edge N+1 (N+2 with ALU_PIPE2_EN).
// No backpressure; rst/rollback flush in-flight work, rdy low freezes every stage and output.
module alu_exec_unit #(
  parameter int ROB_W = alu_exec_unit_pkg::ROB_W,
  parameter int XLEN  = alu_exec_unit_pkg::XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             rollback,
  input  logic             in_config,
  input  logic [XLEN-1:0]  in_value_1,
  input  logic [XLEN-1:0]  in_value_2,
  input  logic [XLEN-1:0]  in_value_pc,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_precise,
  input  logic             in_more_precise,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [ROB_W-1:0] in_rob_entry,
  output logic             alu_config,
  output logic [XLEN-1:0]  alu_val,
  output logic [ROB_W-1:0] alu_rob_entry,
  output logic             alu_jump,
  output logic [XLEN-1:0]  alu_target_pc
);

  import alu_exec_unit_pkg::*;

  issue_t           in_iss;
  issue_t           s0_iss;
  logic             s0_vld;
  logic [ROB_W-1:0] s0_tag;

  exe_t             fin_exe;
  logic             fin_vld;
  logic [ROB_W-1:0] fin_tag;

  logic [XLEN-1:0]  c_val;
  logic [XLEN-1:0]  c_target;
  logic             c_jump;

  assign in_iss = '{in_opcode, in_precise, in_more_precise,
                    in_value_1, in_value_2, in_value_pc, in_imm};

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_vld <= 1'b0;
      s0_iss <= '0;
      s0_tag <= '0;
    end else if (rollback) begin
      s0_vld <= 1'b0;
    end else if (rdy) begin
      s0_vld <= in_config;
      s0_iss <= in_iss;
      s0_tag <= in_rob_entry;
    end
  end

`ifdef ALU_PIPE2_EN
  exe_t             s1_exe;
  logic             s1_vld;
  logic [ROB_W-1:0] s1_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_exe <= '0;
      s1_tag <= '0;
    end else if (rollback) begin
      s1_vld <= 1'b0;
    end else if (rdy) begin
      s1_vld <= s0_vld;
      s1_exe <= prep_exe(s0_iss);
      s1_tag <= s0_tag;
    end
  end

  assign fin_exe = s1_exe;
  assign fin_vld = s1_vld;
  assign fin_tag = s1_tag;
`else
  assign fin_exe = prep_exe(s0_iss);
  assign fin_vld = s0_vld;
  assign fin_tag = s0_tag;
`endif

  alu_compute u_compute (
    .exe    (fin_exe),
    .val    (c_val),
    .jump   (c_jump),
    .target (c_target)
  );

  // Result fields only load on a valid op so they hold between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_config    <= 1'b0;
      alu_val       <= '0;
      alu_rob_entry <= '0;
      alu_jump      <= 1'b0;
      alu_target_pc <= '0;
    end else if (rollback) begin
      alu_config <= 1'b0;
    end else if (rdy) begin
      alu_config <= fin_vld;
      if (fin_vld) begin
        alu_val       <= c_val;
        alu_rob_entry <= fin_tag;
        alu_jump      <= c_jump;
        alu_target_pc <= c_target;
      end
    end
  end

endmodule
